// File: rtl/huffman_pkg.sv
// Shared definitions for the Huffman weight decoder and its symbol packer:
// symbol/word geometry and the packer FSM state encoding.
package huffman_pkg;

  localparam int SYM_W         = 4;
  localparam int WORD_W        = 32;
  localparam int SYMS_PER_WORD = WORD_W / SYM_W;
  localparam int CNT_W         = $clog2(SYMS_PER_WORD + 1);
  localparam int IDX_W         = $clog2(SYMS_PER_WORD);

  typedef enum logic {
    ACCUM = 1'b0,
    STALL = 1'b1
  } state_e;

endpackage

// File: rtl/huffman_pack_outreg.sv
// Output register of the symbol packer: holds one packed word with its valid
// flag, last marker and symbol count, and handles the load/drain handshake.
// Optional macro PACKER_STATS_EN adds saturating word and stall counters.
module huffman_pack_outreg
  import huffman_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [WORD_W-1:0] load_word,
  input  logic              load_last,
  input  logic [CNT_W-1:0]  load_nsyms,
  input  logic              word_ready,
`ifdef PACKER_STATS_EN
  input  logic              stall_cycle,
  output logic [15:0]       stat_words,
  output logic [15:0]       stat_stall_cycles,
`endif
  output logic [WORD_W-1:0] word_out,
  output logic              word_valid,
  output logic              word_last,
  output logic [CNT_W-1:0]  word_nsyms,
  output logic              can_load
);

  // Register is free if empty or being drained this cycle.
  assign can_load = !word_valid || word_ready;

  // Output stage: load a completed word, otherwise clear valid on drain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word_out   <= '0;
      word_valid <= 1'b0;
      word_last  <= 1'b0;
      word_nsyms <= '0;
    end else if (load) begin
      word_out   <= load_word;
      word_valid <= 1'b1;
      word_last  <= load_last;
      word_nsyms <= load_nsyms;
    end else if (word_ready) begin
      word_valid <= 1'b0;
    end
  end

`ifdef PACKER_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Saturating counters of output handshakes and back-pressured input cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_words        <= '0;
      stat_stall_cycles <= '0;
    end else begin
      if (word_valid && word_ready) stat_words <= sat_inc(stat_words);
      if (stall_cycle) stat_stall_cycles <= sat_inc(stat_stall_cycles);
    end
  end
`endif

endmodule

// File: rtl/huffman_symbol_packer.sv
// Packs 4-bit Huffman weight symbols LSB-first into 32-bit words for the L0
// FIFO. Two-deep path (accumulator + output register) absorbs a one-cycle
// L0 stall without back-pressuring the decoder; sym_last flushes a partial
// word. Optional macro PACKER_STATS_EN exposes word/stall statistics.
module huffman_symbol_packer
  import huffman_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [SYM_W-1:0]  sym_in,
  input  logic              sym_valid,
  input  logic              sym_last,
  output logic              sym_ready,
  output logic [WORD_W-1:0] word_out,
  output logic              word_valid,
  input  logic              word_ready,
  output logic              word_last,
  output logic [CNT_W-1:0]  word_nsyms,
`ifdef PACKER_STATS_EN
  output logic [15:0]       stat_words,
  output logic [15:0]       stat_stall_cycles,
`endif
  output logic              busy
);

  state_e              state, state_next;
  logic [WORD_W-1:0]   acc_p0, acc_ins;
  logic [CNT_W-1:0]    count_p0, count_inc;
  logic                last_p0;
  logic [IDX_W-1:0]    idx;
  logic                accept, complete, can_load, load;
  logic [WORD_W-1:0]   load_word;
  logic                load_last;
  logic [CNT_W-1:0]    load_nsyms;

  assign sym_ready = (state == ACCUM);
  assign accept    = sym_valid && sym_ready;
  assign idx       = count_p0[IDX_W-1:0];
  assign count_inc = count_p0 + CNT_W'(1);
  assign complete  = accept && ((count_inc == CNT_W'(SYMS_PER_WORD)) || sym_last);
  assign busy      = word_valid || (count_p0 != '0) || (state == STALL);

  // Insert the incoming symbol at the current fill position.
  always_comb begin
    acc_ins = acc_p0;
    acc_ins[idx*SYM_W +: SYM_W] = sym_in;
  end

  // FSM next state and load request toward the output register.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    load_word  = acc_p0;
    load_last  = last_p0;
    load_nsyms = count_p0;
    case (state)
      ACCUM: begin
        if (complete) begin
          load_word  = acc_ins;
          load_last  = sym_last;
          load_nsyms = count_inc;
          if (can_load) load = 1'b1;
          else          state_next = STALL;
        end
      end
      STALL: begin
        if (can_load) begin
          load       = 1'b1;
          state_next = ACCUM;
        end
      end
      default: state_next = ACCUM;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ACCUM;
    else       state <= state_next;
  end

  // Accumulator stage: clears on transfer, otherwise absorbs accepted symbols.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_p0   <= '0;
      count_p0 <= '0;
      last_p0  <= 1'b0;
    end else if (load) begin
      acc_p0   <= '0;
      count_p0 <= '0;
      last_p0  <= 1'b0;
    end else if (accept) begin
      acc_p0   <= acc_ins;
      count_p0 <= count_inc;
      last_p0  <= sym_last;
    end
  end

  // Output register stage.
  huffman_pack_outreg u_outreg (
    .clk               (clk),
    .reset             (reset),
    .load              (load),
    .load_word         (load_word),
    .load_last         (load_last),
    .load_nsyms        (load_nsyms),
    .word_ready        (word_ready),
`ifdef PACKER_STATS_EN
    .stall_cycle       (sym_valid && !sym_ready),
    .stat_words        (stat_words),
    .stat_stall_cycles (stat_stall_cycles),
`endif
    .word_out          (word_out),
    .word_valid        (word_valid),
    .word_last         (word_last),
    .word_nsyms        (word_nsyms),
    .can_load          (can_load)
  );

endmodule

// File: tb/tb_huffman_symbol_packer.sv
// Scoreboard bench for huffman_symbol_packer: a stream-level model groups
// accepted symbols into words; a negedge monitor checks every output beat.
module tb_huffman_symbol_packer;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  sym_in;
  logic        sym_valid, sym_last, sym_ready;
  logic [31:0] word_out;
  logic        word_valid, word_ready, word_last;
  logic [3:0]  word_nsyms;
  logic        busy;
`ifdef PACKER_STATS_EN
  logic [15:0] stat_words, stat_stall_cycles;
`endif

  huffman_symbol_packer dut (
    .clk               (clk),
    .reset             (reset),
    .sym_in            (sym_in),
    .sym_valid         (sym_valid),
    .sym_last          (sym_last),
    .sym_ready         (sym_ready),
    .word_out          (word_out),
    .word_valid        (word_valid),
    .word_ready        (word_ready),
    .word_last         (word_last),
    .word_nsyms        (word_nsyms),
`ifdef PACKER_STATS_EN
    .stat_words        (stat_words),
    .stat_stall_cycles (stat_stall_cycles),
`endif
    .busy              (busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [31:0] w;
    int          n;
    logic        l;
  } exp_t;

  exp_t expq[$];
  int   part_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor and reference model: busy, hold stability, output beats, acceptance.
  logic        prev_hold = 1'b0;
  logic [31:0] prev_w;
  logic [3:0]  prev_n;
  logic        prev_l;

  always @(negedge clk) begin
    if (reset) begin
      part_q.delete();
      expq.delete();
      prev_hold = 1'b0;
    end else begin
      check("busy", 64'(busy), 64'((expq.size() != 0) || (part_q.size() != 0)));
      if (prev_hold) begin
        check("hold_valid", 64'(word_valid), 64'(1));
        check("hold_word", 64'(word_out), 64'(prev_w));
        check("hold_nsyms", 64'(word_nsyms), 64'(prev_n));
        check("hold_last", 64'(word_last), 64'(prev_l));
      end
      if (word_valid && word_ready) begin
        if (expq.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_word: got %08h with no word expected", word_out);
        end else begin
          exp_t e;
          e = expq.pop_front();
          check("word_out", 64'(word_out), 64'(e.w));
          check("word_nsyms", 64'(word_nsyms), 64'(e.n));
          check("word_last", 64'(word_last), 64'(e.l));
        end
      end
      prev_hold = word_valid && !word_ready;
      prev_w    = word_out;
      prev_n    = word_nsyms;
      prev_l    = word_last;
      if (sym_valid && sym_ready) begin
        part_q.push_back(int'(sym_in));
        if (part_q.size() == 8 || sym_last) begin
          exp_t e;
          e.w = 32'h0;
          for (int i = 0; i < part_q.size(); i++) e.w = e.w | (32'(part_q[i]) << (4 * i));
          e.n = part_q.size();
          e.l = sym_last;
          expq.push_back(e);
          part_q.delete();
        end
      end
    end
  end

  // Offer one symbol until accepted; returns the number of refused cycles.
  task automatic send(input logic [3:0] s, input logic l, output int waits);
    logic took;
    sym_in    = s;
    sym_valid = 1'b1;
    sym_last  = l;
    waits     = 0;
    forever begin
      @(negedge clk);
      took = sym_ready;
      @(posedge clk);
      #1;
      if (took) break;
      waits++;
      if (waits > 60) begin
        $display("FAIL send_timeout: symbol not accepted after %0d cycles", waits);
        $fatal(1, "send timeout");
      end
    end
    sym_valid = 1'b0;
    sym_last  = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(name, 64'(busy), 64'(0));
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_sym_ready"}, 64'(sym_ready), 64'(1));
    check({tag, "_word_out"}, 64'(word_out), 64'(0));
    check({tag, "_word_valid"}, 64'(word_valid), 64'(0));
    check({tag, "_word_last"}, 64'(word_last), 64'(0));
    check({tag, "_word_nsyms"}, 64'(word_nsyms), 64'(0));
    check({tag, "_busy"}, 64'(busy), 64'(0));
  endtask

  initial begin
    int w, tot;
    logic [3:0]  s;
    logic [31:0] ew;

    reset = 1'b1; sym_in = '0; sym_valid = 1'b0; sym_last = 1'b0; word_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("rst0");
    reset = 1'b0;
    @(posedge clk); #1;

    // Symbols 1..8 with L0 ready.
    word_ready = 1'b1;
    for (int i = 1; i <= 8; i++) send(4'(i), 1'b0, w);
    check("t1_valid", 64'(word_valid), 64'(1));
    check("t1_word", 64'(word_out), 64'h87654321);
    check("t1_nsyms", 64'(word_nsyms), 64'(8));
    check("t1_last", 64'(word_last), 64'(0));
    wait_idle("t1_idle");

    // 16 symbols 0xA back to back: no refusal.
    tot = 0;
    for (int i = 0; i < 16; i++) begin
      send(4'hA, 1'b0, w);
      tot += w;
    end
    check("t2_no_stall", 64'(tot), 64'(0));
    wait_idle("t2_idle");

    // Short stream flushed by sym_last.
    send(4'hF, 1'b0, w);
    send(4'h1, 1'b0, w);
    send(4'h2, 1'b1, w);
    check("t3_word", 64'(word_out), 64'h0000021F);
    check("t3_nsyms", 64'(word_nsyms), 64'(3));
    check("t3_last", 64'(word_last), 64'(1));
    wait_idle("t3_idle");

    // Eight symbols ending with sym_last: one full word, no empty follow-up.
    ew = 32'h0;
    for (int i = 0; i < 8; i++) begin
      s = 4'($urandom_range(0, 15));
      ew = ew | (32'(s) << (4 * i));
      send(s, i == 7, w);
    end
    check("t6_word", 64'(word_out), 64'(ew));
    check("t6_nsyms", 64'(word_nsyms), 64'(8));
    check("t6_last", 64'(word_last), 64'(1));
    wait_idle("t6_idle");

    // Stall: L0 not ready while 16 symbols arrive, then 6 refused cycles.
    reset = 1'b1; @(posedge clk); #1; reset = 1'b0;
    @(posedge clk); #1;
    word_ready = 1'b0;
    for (int i = 0; i < 16; i++) send(4'($urandom_range(0, 15)), 1'b0, w);
    check("t4_sym_ready", 64'(sym_ready), 64'(0));
    check("t4_word_valid", 64'(word_valid), 64'(1));
    sym_in = 4'h5; sym_valid = 1'b1; sym_last = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
    end
    word_ready = 1'b1;
    send(4'h5, 1'b1, w);
    check("t4_refused", 64'(w), 64'(1));
    wait_idle("t4_idle");
`ifdef PACKER_STATS_EN
    check("t4_stat_words", 64'(stat_words), 64'(3));
    check("t4_stat_stall", 64'(stat_stall_cycles), 64'(6));
`endif

    // Reset mid-word discards the partial accumulator.
    for (int i = 0; i < 5; i++) send(4'($urandom_range(1, 15)), 1'b0, w);
    reset = 1'b1;
    @(posedge clk); #1;
    check_reset_values("rst1");
    reset = 1'b0;
    @(posedge clk); #1;
    ew = 32'h0;
    for (int i = 0; i < 8; i++) begin
      s = 4'($urandom_range(0, 15));
      ew = ew | (32'(s) << (4 * i));
      send(s, 1'b0, w);
    end
    check("t5_word", 64'(word_out), 64'(ew));
    check("t5_nsyms", 64'(word_nsyms), 64'(8));
    wait_idle("t5_idle");

    // Randomised traffic with random back-pressure and sym_last.
    for (int c = 0; c < 800; c++) begin
      word_ready = ($urandom_range(0, 3) != 0);
      sym_valid  = ($urandom_range(0, 2) != 0);
      sym_in     = 4'($urandom_range(0, 15));
      sym_last   = ($urandom_range(0, 9) == 0);
      @(posedge clk); #1;
    end
    sym_valid  = 1'b0;
    sym_last   = 1'b0;
    word_ready = 1'b1;
    send(4'h3, 1'b1, w);
    wait_idle("rand_idle");
    check("rand_all_drained", 64'(expq.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
